// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-access stage: RV32I load/store funct3 encodings,
// controller states and the misalignment check used when MA_MISALIGN_TRAP_EN is defined.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

endpackage

package mem_access_ctrl_pkg;

    import rv32i_types::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ma_state_t;

    // Word accesses must be word aligned; halfwords may not straddle the word boundary.
    function automatic logic ma_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic r;
        case (funct3)
            LW:      r = (off != 2'b00);
            LH, LHU: r = (off == 2'b11);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load aligner: shifts the addressed byte lane down and
// sign/zero-extends according to funct3 (unknown encodings behave as lw).
module load_align
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;

    // Lane shift followed by width/sign selection.
    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        case (i_funct3)
            LB:      o_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            LBU:     o_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            LH:      o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            LHU:     o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: one registered dcache request per load/store,
// stall until dmem_resp, one-cycle release. MA_MISALIGN_TRAP_EN adds the misaligned trap.
module mem_access_ctrl
    import rv32i_types::*;
    import mem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr_in,
    input  logic [3:0]      mbe_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_mbe,
    output logic            ma_stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);

    ma_state_t       r_state;
    ma_state_t       w_next_state;
    logic            r_dmem_read;
    logic            r_dmem_write;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [3:0]      r_dmem_mbe;
    logic [XLEN-1:0] r_load_data;
    logic            r_load_valid;
    logic            r_misaligned;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic            r_is_load;
    logic            w_mem_op;
    logic            w_accept;
    logic            w_mis;
    logic            w_stall;
    logic [XLEN-1:0] w_load_ext;

    assign w_mem_op = valid_in && (is_load || is_store);
    assign w_accept = (r_state == IDLE) && w_mem_op;

`ifdef MA_MISALIGN_TRAP_EN
    assign w_mis      = ma_misaligned(funct3, addr_in[1:0]);
    assign misaligned = r_misaligned;
`else
    assign w_mis = 1'b0;
`endif

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE never samples EX/MA since it still holds the serviced op.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_mis ? DONE : BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (dmem_resp) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Stall output: raised combinationally at acceptance so EX/MA freezes immediately.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = w_mem_op;
            BUSY:    w_stall = 1'b1;
            DONE:    w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // Request registers and latched instruction context.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_mbe   <= 4'b0000;
            r_load_data  <= '0;
            r_off        <= 2'b00;
            r_funct3     <= 3'b000;
            r_is_load    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_mis) begin
                        r_dmem_read  <= is_load;
                        r_dmem_write <= !is_load;
                        r_dmem_addr  <= {addr_in[XLEN-1:2], 2'b00};
                        r_dmem_wdata <= store_data_in << {addr_in[1:0], 3'b000};
                        r_dmem_mbe   <= mbe_in;
                        r_off        <= addr_in[1:0];
                        r_funct3     <= funct3;
                        r_is_load    <= is_load;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        if (r_is_load) begin
                            r_load_data <= w_load_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // One-cycle completion flags, both visible only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_load_valid <= (r_state == BUSY) && dmem_resp && r_is_load;
            r_misaligned <= w_accept && w_mis;
        end
    end

    assign dmem_read  = r_dmem_read;
    assign dmem_write = r_dmem_write;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_mbe   = r_dmem_mbe;
    assign ma_stall   = w_stall;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;

`ifndef MA_MISALIGN_TRAP_EN
    logic w_unused;
    assign w_unused = r_misaligned;
`endif

endmodule
